hazard_ctrl: RTL and testbench

Parametrised hazard and forwarding controller for the five-stage RISC-V core, replacing the purely combinational hazard unit. It adds four things: correct taken-branch/jump flushing, load-use bubbles with x0 exclusion, a counter-based stall FSM that holds a multi-cycle MUL/DIV op in Execute for a configurable latency, and optional performance counters. It sits beside the datapath and drives the pipeline-register enables and clears plus the Execute-stage forwarding muxes.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/muldiv_stall_fsm.sv | 58 +++++
 rtl/hazard_ctrl.sv | 119 +++++++++++
 tb/tb_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding controller: forward-select codes and
// the MUL/DIV stall FSM state encoding.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/muldiv_stall_fsm.sv
// Holds a multi-cycle MUL/DIV in Execute: busy for MULDIV_LAT-1 cycles, then
// one done cycle in which the op leaves Execute. MULDIV_LAT legal range 2..16.
module muldiv_stall_fsm
  import hazard_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam int unsigned CNT_BITS = $clog2(MULDIV_LAT);
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(MULDIV_LAT - 2);

  md_state_e           state, state_next;
  logic [CNT_BITS-1:0] cnt, cnt_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Start is ignored in the done cycle: it is still the same instruction.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          busy       = 1'b1;
          state_next = BUSY;
          cnt_next   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          busy     = 1'b1;
          cnt_next = cnt - CNT_BITS'(1);
        end else begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the five-stage core: forwarding muxes,
// load-use bubbles, branch flushes and MUL/DIV stalls. Define HAZARD_STATS_EN
// to build the saturating stall/flush statistics counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  MemReadE,
  input  logic                  PCSrcE,
  input  logic                  MulDivStartE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushM,
  output logic                  MulDivBusy,
  output logic                  MulDivDone,
  output logic [CNT_W-1:0]      StallCount,
  output logic [CNT_W-1:0]      FlushCount
);

  logic busy;
  logic load_use;
  logic m_ok, w_ok;
  fwd_sel_e fwd_a, fwd_b;

  muldiv_stall_fsm #(
    .MULDIV_LAT(MULDIV_LAT)
  ) u_muldiv_fsm (
    .clk  (clk),
    .rst_n(rst_n),
    .start(MulDivStartE),
    .busy (busy),
    .done (MulDivDone)
  );

  assign MulDivBusy = busy;

  // Memory stage wins over Writeback; x0 is never forwarded.
  assign m_ok = RegWriteM && (RdM != '0);
  assign w_ok = RegWriteW && (RdW != '0);

  always_comb begin
    fwd_a = FWD_NONE;
    fwd_b = FWD_NONE;
    if (m_ok && (Rs1E == RdM))      fwd_a = FWD_M;
    else if (w_ok && (Rs1E == RdW)) fwd_a = FWD_W;
    if (m_ok && (Rs2E == RdM))      fwd_b = FWD_M;
    else if (w_ok && (Rs2E == RdW)) fwd_b = FWD_W;
  end

  assign ForwardAE = fwd_a;
  assign ForwardBE = fwd_b;

  assign load_use = MemReadE && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));

  // Priority: MUL/DIV busy, taken branch, load-use.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (busy) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (load_use) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (StallD && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (PCSrcE && !busy && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign StallCount = stall_cnt;
  assign FlushCount = flush_cnt;
`else
  assign StallCount = '0;
  assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, hand-written
// MUL/DIV sequences and randomized traffic against a cycle-phase model.
module tb_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       regwm, regww, memre, pcsrc, start, rst_n;
  } vec_t;

  // ctl = {StallF, StallD, StallE, FlushD, FlushE, FlushM}
  typedef struct packed {
    logic [1:0] fa, fb;
    logic [5:0] ctl;
    logic       busy, done;
  } outs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, MemReadE, PCSrcE, MulDivStartE;

  logic [1:0]  fa1, fb1, fa2, fb2;
  logic        sf1, sd1, se1, fd1, fe1, fm1, bz1, dn1;
  logic        sf2, sd2, se2, fd2, fe2, fm2, bz2, dn2;
  logic [31:0] sc1, fc1, sc2, fc2;

  hazard_ctrl #(.REG_ADDR_W(5), .MULDIV_LAT(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReadE(MemReadE), .PCSrcE(PCSrcE),
    .MulDivStartE(MulDivStartE),
    .ForwardAE(fa1), .ForwardBE(fb1),
    .StallF(sf1), .StallD(sd1), .StallE(se1), .FlushD(fd1), .FlushE(fe1), .FlushM(fm1),
    .MulDivBusy(bz1), .MulDivDone(dn1), .StallCount(sc1), .FlushCount(fc1)
  );

  hazard_ctrl #(.REG_ADDR_W(5), .MULDIV_LAT(2), .CNT_W(32)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReadE(MemReadE), .PCSrcE(PCSrcE),
    .MulDivStartE(MulDivStartE),
    .ForwardAE(fa2), .ForwardBE(fb2),
    .StallF(sf2), .StallD(sd2), .StallE(se2), .FlushD(fd2), .FlushE(fe2), .FlushM(fm2),
    .MulDivBusy(bz2), .MulDivDone(dn2), .StallCount(sc2), .FlushCount(fc2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state per instance: k = cycles since the MUL/DIV entered Execute (0 = none).
  int     k1 = 0, k2 = 0;
  longint sc1_m = 0, fc1_m = 0, sc2_m = 0, fc2_m = 0;
  localparam longint SAT = 64'hFFFF_FFFF;

  function automatic vec_t mkv(int rs1d, int rs2d, int rs1e, int rs2e, int rde, int rdm, int rdw,
                               bit regwm, bit regww, bit memre, bit pcsrc, bit start, bit rstn);
    vec_t v;
    v.rs1d = 5'(rs1d); v.rs2d = 5'(rs2d); v.rs1e = 5'(rs1e); v.rs2e = 5'(rs2e);
    v.rde = 5'(rde); v.rdm = 5'(rdm); v.rdw = 5'(rdw);
    v.regwm = regwm; v.regww = regww; v.memre = memre; v.pcsrc = pcsrc;
    v.start = start; v.rst_n = rstn;
    return v;
  endfunction

  function automatic outs_t mko(int fa, int fb, logic [5:0] ctl, bit busy, bit done);
    outs_t o;
    o.fa = 2'(fa); o.fb = 2'(fb); o.ctl = ctl; o.busy = busy; o.done = done;
    return o;
  endfunction

  function automatic logic [1:0] fwd_ref(logic [4:0] rs, vec_t v);
    if (v.regwm && v.rdm != 0 && rs == v.rdm) return 2'b10;
    if (v.regww && v.rdw != 0 && rs == v.rdw) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit busy_ref(vec_t v, int k, int lat);
    return (k == 0 && v.start) || (k >= 1 && k <= lat - 2);
  endfunction

  function automatic outs_t model(vec_t v, int k, int lat);
    outs_t o;
    bit lu;
    o = '0;
    o.fa   = fwd_ref(v.rs1e, v);
    o.fb   = fwd_ref(v.rs2e, v);
    o.busy = busy_ref(v, k, lat);
    o.done = (k != 0) && (k == lat - 1);
    lu = v.memre && v.rde != 0 && (v.rs1d == v.rde || v.rs2d == v.rde);
    if (o.busy)       o.ctl = 6'b111001;
    else if (v.pcsrc) o.ctl = 6'b000110;
    else if (lu)      o.ctl = 6'b110010;
    return o;
  endfunction

  function automatic int next_k(vec_t v, int k, int lat);
    if (!v.rst_n) return 0;
    if (k == 0)   return v.start ? 1 : 0;
    return (k >= lat - 1) ? 0 : k + 1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_outs(input string nm, input outs_t a, input outs_t e);
    chk({nm, ".ForwardAE"}, 64'(a.fa), 64'(e.fa));
    chk({nm, ".ForwardBE"}, 64'(a.fb), 64'(e.fb));
    chk({nm, ".stall_flush"}, 64'(a.ctl), 64'(e.ctl));
    chk({nm, ".busy_done"}, 64'({a.busy, a.done}), 64'({e.busy, e.done}));
  endtask

  // Apply one vector, check both instances, advance one clock and the model.
  task automatic step(input vec_t v, input bit use_exp, input outs_t e, input string nm);
    outs_t a1, a2, m1, m2;
    longint esc1, efc1, esc2, efc2;
    Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
    RdE = v.rde; RdM = v.rdm; RdW = v.rdw;
    RegWriteM = v.regwm; RegWriteW = v.regww; MemReadE = v.memre;
    PCSrcE = v.pcsrc; MulDivStartE = v.start; rst_n = v.rst_n;
    #2;
    a1 = '{fa: fa1, fb: fb1, ctl: {sf1, sd1, se1, fd1, fe1, fm1}, busy: bz1, done: dn1};
    a2 = '{fa: fa2, fb: fb2, ctl: {sf2, sd2, se2, fd2, fe2, fm2}, busy: bz2, done: dn2};
    m1 = model(v, k1, 4);
    m2 = model(v, k2, 2);
    cmp_outs({nm, ".lat4"}, a1, use_exp ? e : m1);
    cmp_outs({nm, ".lat2"}, a2, m2);
`ifdef HAZARD_STATS_EN
    esc1 = sc1_m; efc1 = fc1_m; esc2 = sc2_m; efc2 = fc2_m;
`else
    esc1 = 0; efc1 = 0; esc2 = 0; efc2 = 0;
`endif
    chk({nm, ".lat4.StallCount"}, 64'(sc1), 64'(esc1));
    chk({nm, ".lat4.FlushCount"}, 64'(fc1), 64'(efc1));
    chk({nm, ".lat2.StallCount"}, 64'(sc2), 64'(esc2));
    chk({nm, ".lat2.FlushCount"}, 64'(fc2), 64'(efc2));
    @(posedge clk);
    if (!v.rst_n) begin
      sc1_m = 0; fc1_m = 0; sc2_m = 0; fc2_m = 0;
    end else begin
      if (m1.ctl[4] && sc1_m < SAT) sc1_m++;
      if (m2.ctl[4] && sc2_m < SAT) sc2_m++;
      if (v.pcsrc && !m1.busy && fc1_m < SAT) fc1_m++;
      if (v.pcsrc && !m2.busy && fc2_m < SAT) fc2_m++;
    end
    k1 = next_k(v, k1, 4);
    k2 = next_k(v, k2, 2);
    #1;
  endtask

  vec_t  tv[12];
  outs_t te[12];
  outs_t busy_o, done_o, idle_o;
  vec_t  idle_v, start_v, rst_v, mask_v, rv;

  initial begin
    busy_o  = mko(0, 0, 6'b111001, 1, 0);
    done_o  = mko(0, 0, 6'b000000, 0, 1);
    idle_o  = '0;
    idle_v  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    start_v = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    rst_v   = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mask_v  = mkv(1, 7, 0, 0, 7, 0, 0, 0, 0, 1, 1, 0, 1);

    //            rs1d rs2d rs1e rs2e rde rdm rdw  wm ww mr pc st rst
    tv[0]  = mkv(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1); te[0]  = idle_o;
    tv[1]  = mkv(0, 0, 5, 0, 0, 5, 5,   1, 1, 0, 0, 0, 1); te[1]  = mko(2, 0, 0, 0, 0);
    tv[2]  = mkv(0, 0, 5, 0, 0, 5, 5,   0, 1, 0, 0, 0, 1); te[2]  = mko(1, 0, 0, 0, 0);
    tv[3]  = mkv(0, 0, 5, 0, 0, 0, 0,   1, 1, 0, 0, 0, 1); te[3]  = mko(0, 0, 0, 0, 0);
    tv[4]  = mkv(0, 0, 3, 4, 0, 3, 4,   1, 1, 0, 0, 0, 1); te[4]  = mko(2, 1, 0, 0, 0);
    tv[5]  = mkv(0, 0, 9, 9, 0, 9, 9,   0, 0, 0, 0, 0, 1); te[5]  = mko(0, 0, 0, 0, 0);
    tv[6]  = mkv(1, 7, 0, 0, 7, 0, 0,   0, 0, 1, 0, 0, 1); te[6]  = mko(0, 0, 6'b110010, 0, 0);
    tv[7]  = mkv(7, 2, 0, 0, 7, 0, 0,   0, 0, 1, 0, 0, 1); te[7]  = mko(0, 0, 6'b110010, 0, 0);
    tv[8]  = mkv(0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 1); te[8]  = idle_o;
    tv[9]  = mkv(1, 7, 0, 0, 7, 0, 0,   0, 0, 0, 0, 0, 1); te[9]  = idle_o;
    tv[10] = mkv(1, 7, 0, 0, 7, 0, 0,   0, 0, 1, 1, 0, 1); te[10] = mko(0, 0, 6'b000110, 0, 0);
    tv[11] = mkv(0, 0, 6, 6, 0, 6, 0,   1, 0, 0, 1, 0, 1); te[11] = mko(2, 2, 6'b000110, 0, 0);

    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, MemReadE, PCSrcE, MulDivStartE} = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) step(tv[i], 1'b1, te[i], $sformatf("vec%0d", i));

    // MUL/DIV held high: busy 3, done 1, restart from idle.
    for (int i = 0; i < 8; i++)
      step(start_v, 1'b1, (i % 4 == 3) ? done_o : busy_o, $sformatf("lat%0d", i));
    step(idle_v, 1'b1, idle_o, "lat_idle");

    // Load-use and branch in the second busy cycle are masked.
    step(start_v, 1'b1, busy_o, "mask0");
    step(mask_v,  1'b1, busy_o, "mask1");
    step(idle_v,  1'b1, busy_o, "mask2");
    step(idle_v,  1'b1, done_o, "mask3");
    step(idle_v,  1'b1, idle_o, "mask4");

    // Reset in the second busy cycle, then a full new operation.
    step(start_v, 1'b1, busy_o, "rst0");
    step(rst_v,   1'b1, busy_o, "rst1");
    step(idle_v,  1'b1, idle_o, "rst2");
    step(start_v, 1'b1, busy_o, "rst3");
    step(idle_v,  1'b1, busy_o, "rst4");
    step(idle_v,  1'b1, busy_o, "rst5");
    step(idle_v,  1'b1, done_o, "rst6");
    step(idle_v,  1'b1, idle_o, "rst7");

    for (int i = 0; i < 600; i++) begin
      rv = mkv($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 4) == 0, $urandom_range(0, 40) != 0);
      step(rv, 1'b0, idle_o, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
